encoder_seq: RTL

//   Sequential one-hot-to-binary encoder: inverse of the team's 2-to-4 decoder.
//   - Accepts an N-bit select vector over a valid/ready handshake.
//   - Scans it one bit per clock and returns the binary index of the lowest set bit.
//   - Flags empty and multi-hot inputs.
//   - Sits on the return path of decoder-driven select lines, re-encoding them for status/checking.

---
 rtl/encoder_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/encoder_seq.sv
// Sequential one-hot-to-binary encoder: scans a captured N-bit select vector one
// bit per clock and reports the lowest set index plus empty/multi-hot flags.
module encoder_seq #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         out_zero,
    output logic         out_multi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_vec;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_scan_code;
    logic           r_found;
    logic           r_multi;
    logic           w_bit;
    logic           w_last;

    assign w_bit  = r_vec[r_cnt];
    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_scan_code <= '0;
            r_found     <= 1'b0;
            r_multi     <= 1'b0;
            out_code    <= '0;
            out_zero    <= 1'b0;
            out_multi   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_vec       <= in_vec;
                        r_cnt       <= '0;
                        r_scan_code <= '0;
                        r_found     <= 1'b0;
                        r_multi     <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                    if (w_bit) begin
                        if (!r_found) begin
                            r_scan_code <= r_cnt;
                            r_found     <= 1'b1;
                        end else begin
                            r_multi <= 1'b1;
                        end
                    end
                    // Final bit folds straight into the published result.
                    if (w_last) begin
                        out_code  <= (w_bit && !r_found) ? r_cnt : r_scan_code;
                        out_zero  <= !(r_found || w_bit);
                        out_multi <= r_multi || (w_bit && r_found);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
